// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   - register offsets inside the 8-byte window
//   - STATUS bit positions
//   - FSM state encoding
//   - a helper that packs the STATUS word
package mmio_uart_pkg;

  localparam logic [2:0] OFS_TXDATA = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd4;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_ACTIVE    = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_e;

  // Assemble the STATUS word; unlisted bits read as zero.
  function automatic logic [31:0] packStatus(
    input logic       full,
    input logic       empty,
    input logic       active,
    input logic       ovf,
    input logic [7:0] count
  );
    logic [31:0] word;
    word                           = 32'h0000_0000;
    word[STAT_FULL]                = full;
    word[STAT_EMPTY]               = empty;
    word[STAT_ACTIVE]              = active;
    word[STAT_OVF]                 = ovf;
    word[STAT_COUNT_LSB +: 8]      = count;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, reset (async, active-high)
//   push/din  : write request and data (ignored when full unless popping in the same cycle)
//   pop       : read request (ignored when empty)
//   dout      : head entry, valid whenever !empty
//   full, empty, count : occupancy flags and entry count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [AW:0]      count_r;
  logic             doPush_s;
  logic             doPop_s;

  // A pop frees the slot the write lands in, so a full FIFO still accepts a simultaneous push.
  assign doPop_s  = pop && !empty;
  assign doPush_s = push && (!full || doPop_s);

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;
  assign dout  = mem_r[rdPtr_r];

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (doPush_s) begin
      mem_r[wrPtr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (doPush_s) begin
        wrPtr_r <= wrPtr_r + AW'(1);
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + AW'(1);
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory.
// Ports:
//   clk, reset (async, active-high)
//   we, a, wd : processor store strobe, byte address, store data
//   rd        : STATUS when reading BASE+4, else 0 (combinational)
//   hit       : address falls in the 8-byte window (combinational)
//   tx        : serial line, idle high (registered)
//   busy      : FIFO non-empty or frame in progress (registered)
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  uartState_e  state_r, nextState_s;
  logic [CW-1:0] baudCnt_r, baudNext_s;
  logic [2:0]  bitIdx_r, bitNext_s;
  logic [7:0]  shift_r, shiftNext_s;
  logic        tx_r, txNext_s;
  logic        busy_r, busyNext_s;
  logic        ovf_r;

  logic        isTxData_s, isStatus_s;
  logic        pushReq_s, pushAcc_s, pop_s, clrOvf_s, setOvf_s, baudDone_s;
  logic [7:0]  fifoDout_s;
  logic        fifoFull_s, fifoEmpty_s;
  logic [AW:0] fifoCount_s, cntNext_s;
  logic        unusedBits_s;

  assign unusedBits_s = ^{wd[31:8], a[1:0]};

  // Decode: a[2] picks the register, a[1:0] is don't-care.
  assign hit        = (a[31:3] == BASE_ADDR[31:3]);
  assign isTxData_s = ({a[2], 2'b00} == OFS_TXDATA);
  assign isStatus_s = ({a[2], 2'b00} == OFS_STATUS);

  assign pushReq_s  = we && hit && isTxData_s;
  assign clrOvf_s   = we && hit && isStatus_s && wd[STAT_OVF];
  assign pop_s      = (state_r == IDLE) && !fifoEmpty_s;
  assign pushAcc_s  = pushReq_s && (!fifoFull_s || pop_s);
  assign setOvf_s   = pushReq_s && fifoFull_s && !pop_s;
  assign baudDone_s = (baudCnt_r == CW'(CLKS_PER_BIT - 1));
  assign cntNext_s  = fifoCount_s + (AW+1)'(pushAcc_s) - (AW+1)'(pop_s);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq_s),
    .pop   (pop_s),
    .din   (wd[7:0]),
    .dout  (fifoDout_s),
    .full  (fifoFull_s),
    .empty (fifoEmpty_s),
    .count (fifoCount_s)
  );

  // Read mux: STATUS only; TXDATA and misses read as zero.
  always_comb begin
    if (hit && isStatus_s) begin
      rd = packStatus(fifoFull_s, fifoEmpty_s, state_r != IDLE, ovf_r, 8'(fifoCount_s));
    end else begin
      rd = 32'h0000_0000;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:    if (!fifoEmpty_s) nextState_s = START; else nextState_s = IDLE;
      START:   if (baudDone_s) nextState_s = DATA; else nextState_s = START;
      DATA:    if (baudDone_s && bitIdx_r == 3'd7) nextState_s = STOP; else nextState_s = DATA;
      STOP:    if (baudDone_s) nextState_s = IDLE; else nextState_s = STOP;
      default: nextState_s = IDLE;
    endcase
  end

  // FSM outputs: datapath next values and the line level for the state being entered.
  always_comb begin
    baudNext_s  = baudCnt_r;
    bitNext_s   = bitIdx_r;
    shiftNext_s = shift_r;
    case (state_r)
      IDLE: begin
        baudNext_s = {CW{1'b0}};
        bitNext_s  = 3'd0;
        if (!fifoEmpty_s) shiftNext_s = fifoDout_s; else shiftNext_s = shift_r;
      end
      START, STOP: begin
        if (baudDone_s) baudNext_s = {CW{1'b0}}; else baudNext_s = baudCnt_r + CW'(1);
      end
      DATA: begin
        if (baudDone_s) begin
          baudNext_s  = {CW{1'b0}};
          bitNext_s   = bitIdx_r + 3'd1;
          shiftNext_s = {1'b0, shift_r[7:1]};
        end else begin
          baudNext_s  = baudCnt_r + CW'(1);
        end
      end
      default: baudNext_s = {CW{1'b0}};
    endcase

    // tx is registered, so it is driven from the state about to be entered.
    case (nextState_s)
      START:   txNext_s = 1'b0;
      DATA:    txNext_s = shiftNext_s[0];
      default: txNext_s = 1'b1;
    endcase

    busyNext_s = (nextState_s != IDLE) || (cntNext_s != {(AW+1){1'b0}});
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baudCnt_r <= {CW{1'b0}};
      bitIdx_r  <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      baudCnt_r <= baudNext_s;
      bitIdx_r  <= bitNext_s;
      shift_r   <= shiftNext_s;
      tx_r      <= txNext_s;
      busy_r    <= busyNext_s;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (setOvf_s) begin
      ovf_r <= 1'b1;
    end else if (clrOvf_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT = 4, FIFO_DEPTH = 4).
// The reference model keeps a timeline of accepted bytes and their frame
// start edges; line level, occupancy and STATUS follow from that timeline.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset, we, hit, tx, busy;
  logic [31:0] a, wd, rd;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .hit(hit), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model timeline: accepted push edge, frame start edge, byte.
  int         pEdge[$];
  int         fStart[$];
  logic [7:0] fByte[$];
  logic       ovf = 1'b0;

  function automatic int countAfter(int k);
    int n = 0;
    for (int i = 0; i < pEdge.size(); i++) begin
      if (pEdge[i] <= k) n++;
      if (fStart[i] <= k) n--;
    end
    return n;
  endfunction

  function automatic bit popAt(int k);
    for (int i = 0; i < fStart.size(); i++) if (fStart[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit activeAt(int k);
    for (int i = 0; i < fStart.size(); i++)
      if (k >= fStart[i] && k < fStart[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic txAt(int k);
    for (int i = 0; i < fStart.size(); i++) begin
      if (k >= fStart[i] && k < fStart[i] + FRAME) begin
        int j = (k - fStart[i]) / CPB;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return fByte[i][j-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] statusAt(int k);
    int c = countAfter(k);
    logic [31:0] s = 32'h0;
    s[0]    = (c == DEPTH);
    s[1]    = (c == 0);
    s[2]    = activeAt(k);
    s[3]    = ovf;
    s[15:8] = 8'(c);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Apply the store effects of edge cyc to the model.
  task automatic modelEdge(input logic w, input logic [31:0] ad, input logic [31:0] d);
    bit hitM = (ad[31:3] == BASE[31:3]);
    bit setO = 1'b0;
    if (w && hitM && !ad[2]) begin
      if (countAfter(cyc - 1) < DEPTH || popAt(cyc)) begin
        int s = cyc + 1;
        if (fStart.size() != 0 && fStart[$] + FRAME + 1 > s) s = fStart[$] + FRAME + 1;
        pEdge.push_back(cyc);
        fStart.push_back(s);
        fByte.push_back(d[7:0]);
      end else begin
        setO = 1'b1;
      end
    end
    if (setO) ovf = 1'b1;
    else if (w && hitM && ad[2] && d[3]) ovf = 1'b0;
  endtask

  // One clock: drive inputs, update the model at the edge, check after it.
  task automatic step(input logic w, input logic [31:0] ad, input logic [31:0] d);
    we = w; a = ad; wd = d;
    @(posedge clk);
    cyc++;
    modelEdge(w, ad, d);
    @(negedge clk);
    we = 1'b0; a = BASE + 32'd4; wd = 32'h0;
    #1;
    check("tx", {31'h0, tx}, {31'h0, txAt(cyc)});
    check("busy", {31'h0, busy}, {31'h0, (countAfter(cyc) > 0) || activeAt(cyc)});
    check("status", rd, statusAt(cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, BASE + 32'd4, 32'h0);
  endtask

  task automatic clearModel();
    pEdge.delete(); fStart.delete(); fByte.delete(); ovf = 1'b0;
  endtask

  logic [9:0] pat;
  int storeCyc;

  initial begin
    reset = 1'b1; we = 1'b0; a = BASE + 32'd4; wd = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    // Reset state
    check("rstStatus", rd, 32'h0000_0002);
    check("rstTx", {31'h0, tx}, 32'h1);
    check("rstBusy", {31'h0, busy}, 32'h0);
    idle(3);

    // Single byte 0x55: bit-centre samples and busy drop
    pat = 10'b10_1010_1010;
    step(1'b1, BASE, 32'hDEAD_BE55);
    storeCyc = cyc;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, BASE + 32'd4, 32'h0);
      if (cyc - storeCyc - 1 < FRAME && (cyc - storeCyc - 1) % CPB == 2)
        check("bitCentre", {31'h0, tx}, {31'h0, pat[(cyc - storeCyc - 1) / CPB]});
      if (cyc == storeCyc + 40) check("busyHeld", {31'h0, busy}, 32'h1);
      if (cyc == storeCyc + 41) check("busyDrop", {31'h0, busy}, 32'h0);
    end

    // Back-to-back frames
    step(1'b1, BASE, 32'h41);
    step(1'b1, BASE + 32'd1, 32'h42);
    step(1'b1, BASE + 32'd3, 32'h43);
    check("b2bCount", {24'h0, rd[15:8]}, 32'd2);
    idle(3 * (FRAME + 1) + 5);

    // Overflow while in DATA with the FIFO full
    step(1'b1, BASE, 32'h11);
    idle(8);
    for (int i = 0; i < 4; i++) step(1'b1, BASE, 32'h20 + 32'(i));
    step(1'b1, BASE, 32'h99);
    check("ovfStatus", rd, 32'h0000_040D);
    step(1'b1, BASE + 32'd4, 32'h8);
    check("ovfClear", rd, 32'h0000_0405);
    idle(5 * (FRAME + 1) + 5);

    // Address decode
    step(1'b1, BASE + 32'd8, 32'h77);
    step(1'b1, 32'h1234_5670, 32'hFF);
    a = BASE + 32'd8; #1;
    check("hitOutside", {31'h0, hit}, 32'h0);
    check("rdOutside", rd, 32'h0);
    a = BASE; #1;
    check("hitTxData", {31'h0, hit}, 32'h1);
    check("rdTxData", rd, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 4)       step(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom());
      else if (r == 4) step(1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom());
      else if (r == 5) step(1'b1, BASE + 32'd8 + 32'($urandom_range(0, 7)), $urandom());
      else             step(1'b0, $urandom(), $urandom());
    end
    idle(5 * (FRAME + 1) + 5);

    // Reset mid-frame during DATA bit 3
    step(1'b1, BASE, 32'hA5);
    idle(18);
    check("preResetTx", {31'h0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("asyncTx", {31'h0, tx}, 32'h1);
    check("asyncBusy", {31'h0, busy}, 32'h0);
    clearModel();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("postResetStatus", rd, 32'h0000_0002);
    step(1'b1, BASE, 32'h3C);
    idle(FRAME + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
